// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder controller. It computes {cout,sum} = a + b + cin one bit
//   per clock, LSB first, with a single 1-bit full adder. An operation takes
//   WIDTH cycles in ADD. A one-cycle DONE state then follows, and the block
//   returns to IDLE.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; sum/cout hold the last result
//   ADD   | one operand bit pair added per edge, WIDTH edges in total
//   DONE  | single-cycle completion pulse; sum/cout freshly loaded
//
// Ports
//   clk    : clock, rising-edge active
//   rst    : asynchronous active-high reset
//   start  : begin an addition (sampled only in IDLE)
//   a, b   : WIDTH-bit addends
//   cin    : carry-in
//   busy   : high while in ADD
//   done   : high for the single DONE cycle
//   sum    : registered WIDTH-bit result
//   cout   : registered carry-out of bit WIDTH-1
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // The counter must be able to hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  // The single full adder, shared across all bit positions over time.
  logic fa_x, fa_y, fa_s, fa_c;
  assign fa_x = sh_a[0];
  assign fa_y = sh_b[0];
  assign fa_s = fa_x ^ fa_y ^ carry;
  assign fa_c = (fa_x & fa_y) | (carry & (fa_x ^ fa_y));

  // Each sum bit enters at the MSB. After WIDTH shifts, bit 0 has reached
  // the LSB position.
  logic [WIDTH-1:0] res_next;
  assign res_next = {fa_s, res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          res   <= res_next;
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          // This is the WIDTH-th edge, so the result leaves on the same edge.
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= res_next;
            cout  <= fa_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int vectors = 0;
  int miscompares = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on the captured operands.
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  // Runs one addition. With full=1, it also checks timing, the busy length
  // and the output stability. With disturb=1, it changes the operands and
  // pulses start in the middle of the operation.
  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc,
                       input bit full, input bit disturb);
    logic [WIDTH:0] exp;
    logic [WIDTH:0] prev;
    int  busy_cnt;
    int  cyc;
    int  extra_done;
    bit  stable;
    exp   = ref_add(ta, tb_v, tc);
    prev  = {cout, sum};
    a     = ta;
    b     = tb_v;
    cin   = tc;
    start = 1'b1;
    tick();
    start    = 1'b0;
    busy_cnt = 0;
    cyc      = 0;
    stable   = 1'b1;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      if ({cout, sum} !== prev) stable = 1'b0;
      if (disturb) begin
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
        start = (cyc == 2);
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    check("sum", {24'd0, sum}, {24'd0, exp[WIDTH-1:0]});
    check("cout", {31'd0, cout}, {31'd0, exp[WIDTH]});
    if (full) begin
      check("latency", cyc, WIDTH);
      check("busy_len", busy_cnt, WIDTH);
      check("busy_in_done", {31'd0, busy}, 32'd0);
      check("out_stable_mid_op", {31'd0, stable}, 32'd1);
    end
    tick();
    if (full) check("done_one_cycle", {31'd0, done}, 32'd0);
    if (disturb) begin
      extra_done = 0;
      for (int i = 0; i < 12; i++) begin
        if (done || busy) extra_done++;
        tick();
      end
      check("no_queued_start", extra_done, 0);
      check("sum_hold_idle", {23'd0, cout, sum}, {23'd0, exp});
    end
  endtask

  initial begin
    int last;
    int ndone;
    logic [WIDTH-1:0] ra, rb;
    logic rc;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    #10;
    rst = 1'b0;   // Released at t=12. The first start must be taken at the edge at t=15.

    do_op(8'h3C, 8'h05, 1'b0, 1, 0);
    do_op(8'hFF, 8'h01, 1'b0, 1, 0);
    do_op(8'h00, 8'h00, 1'b1, 1, 0);
    do_op(8'h81, 8'h7E, 1'b1, 1, 1);

    // Abort in the fourth ADD cycle. The previous result is nonzero, so it can be seen to clear.
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum", {24'd0, sum}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      tick();
    end
    check("abort_no_done", ndone, 0);
    do_op(8'h12, 8'h34, 1'b0, 1, 0);

    // With start held high, an operation begins every WIDTH+2 cycles.
    a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
    last  = -1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin
        check("hold_sum", {24'd0, sum}, 32'h00);
        check("hold_cout", {31'd0, cout}, 32'd1);
        if (last < 0) check("hold_first_done", i, WIDTH);
        else          check("hold_interval", i - last, WIDTH + 2);
        last = i;
        ndone++;
      end
    end
    start = 1'b0;
    check("hold_done_count", ndone, 4);
    repeat (12) tick();

    for (int n = 0; n < 1000; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      do_op(ra, rb, rc, (n % 50) == 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH, addend A.
REQ-006 The block SHALL have port b, input, WIDTH, addend B.
REQ-007 The block SHALL have port cin, input, 1, carry-in.
REQ-008 The block SHALL have port busy, output, 1, high while an addition is in progress.
REQ-009 The block SHALL have port done, output, 1, single-cycle completion pulse.
REQ-010 The block SHALL have port sum, output, WIDTH, registered result.
REQ-011 The block SHALL have port cout, output, 1, registered carry-out of bit WIDTH-1.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, using exactly one 1-bit full-adder instance (sum = x^y^c, carry = xy | c(x^y)) per cycle.
REQ-013 The FSM SHALL have exactly three states: IDLE, ADD, DONE.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL capture a, b and cin into internal shift registers and a carry flop, clear the bit counter, and enter ADD.
REQ-015 In IDLE with start=0, the block SHALL stay in IDLE and hold sum and cout.
REQ-016 Each rising edge in ADD SHALL add the operand LSBs and the carry flop, shift the sum bit into the MSB of an internal result register, right-shift both operands, update the carry flop, and increment the counter.
REQ-017 After the WIDTH-th ADD edge, the block SHALL enter DONE and load sum from the result register and cout from the carry flop on that same edge.
REQ-018 DONE SHALL last exactly one cycle and then return unconditionally to IDLE.
REQ-019 busy SHALL be high exactly when the state is ADD; done SHALL be high exactly when the state is DONE.
REQ-020 Latency: if start is sampled at edge k, done SHALL be high in the cycle following edge k+WIDTH, with sum and cout valid in that cycle.
REQ-021 sum and cout SHALL remain stable from DONE until the next DONE; a new start SHALL NOT disturb them mid-operation.
REQ-022 start asserted in ADD or DONE SHALL be ignored, and SHALL NOT be queued.
REQ-023 Changes on a, b or cin after capture SHALL NOT affect the result in progress.
REQ-024 With start held high continuously, operations SHALL begin every WIDTH+2 cycles.
REQ-025 The bit counter SHALL be wide enough to hold WIDTH, and SHALL NOT wrap within an operation.

Reset
REQ-026 While rst=1, the block SHALL force the state to IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, shift registers and carry flop, without waiting for a clock edge.
REQ-027 A reset asserted mid-ADD SHALL abort the operation with no done pulse.
REQ-028 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-029 Bench: WIDTH=8, a=8'h3C, b=8'h05, cin=0, start pulsed -> busy high for 8 cycles, then done for 1 cycle, with sum=8'h41 and cout=0.
REQ-030 Bench: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; then a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
REQ-031 Bench: start pulsed again during busy, and a/b changed mid-operation -> the original result is unchanged and there is exactly one done pulse.
REQ-032 Bench: rst asserted at ADD cycle 4 -> outputs are 0 immediately with no done; a subsequent start yields a correct result.
REQ-033 Bench: start held high with a=8'hAA, b=8'h55, cin=1 -> done every 10 cycles, with sum=8'h00 and cout=1.
REQ-034 Bench: 1000 random a/b/cin cases -> {cout,sum} equals the reference sum for every done pulse.
